imm_seq_ctrl: RTL and testbench

- Multi-cycle control sequencer for the NPC datapath.
- Fetches one instruction through an IFU handshake, latches it, and drives the immediate generator's ImmSel from the opcode.
- Sequences execute, memory and writeback, emitting register-file, memory and PC-update strobes.
- Sits between the IFU/LSU handshake agents and the existing immediate-generator/ALU/regfile datapath.

---
 rtl/imm_seq_ctrl_pkg.sv | 60 ++++++
 rtl/imm_seq_decode.sv | 74 +++++++
 rtl/imm_seq_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_imm_seq_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_seq_ctrl_pkg.sv
// Shared definitions for the imm_seq_ctrl sequencer: opcodes, ImmSel codes,
// pc_sel codes, FSM state encodings and the instruction class enumeration.
package imm_seq_ctrl_pkg;

  localparam int unsigned INST_W    = 32;
  localparam int unsigned IMM_SEL_W = 3;
  localparam int unsigned PC_SEL_W  = 2;
  localparam int unsigned WDOG_W    = 16;
  localparam int unsigned CLS_W     = 4;

  // Base opcodes, inst[6:0]
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [INST_W-1:0] INST_EBREAK = 32'h0010_0073;

  // Immediate generator select codes
  localparam logic [IMM_SEL_W-1:0] IMM_U    = 3'b000;
  localparam logic [IMM_SEL_W-1:0] IMM_I    = 3'b001;
  localparam logic [IMM_SEL_W-1:0] IMM_S    = 3'b010;
  localparam logic [IMM_SEL_W-1:0] IMM_B    = 3'b011;
  localparam logic [IMM_SEL_W-1:0] IMM_J    = 3'b100;
  localparam logic [IMM_SEL_W-1:0] IMM_ZIMM = 3'b101;

  // Next-PC source select
  localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ  = 2'd0;
  localparam logic [PC_SEL_W-1:0] PC_SEL_REL  = 2'd1;
  localparam logic [PC_SEL_W-1:0] PC_SEL_JALR = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_STOP   = 3'd6
  } state_e;

  typedef enum logic [CLS_W-1:0] {
    CLS_ALU     = 4'd0,
    CLS_LOAD    = 4'd1,
    CLS_STORE   = 4'd2,
    CLS_BRANCH  = 4'd3,
    CLS_JAL     = 4'd4,
    CLS_JALR    = 4'd5,
    CLS_CSR     = 4'd6,
    CLS_EBREAK  = 4'd7,
    CLS_ILLEGAL = 4'd8
  } inst_cls_e;

endpackage

// File: rtl/imm_seq_decode.sv
// Combinational instruction decoder for imm_seq_ctrl.
// Ports: inst (instruction word) -> imm_sel_c (ImmSel code), cls_c
// (instruction class), wb_en_c (instruction writes the register file).
// Optional feature macro: IMM_SEQ_CTRL_ZICSR_EN enables CSR decode.
module imm_seq_decode
  import imm_seq_ctrl_pkg::*;
(
  input  logic [INST_W-1:0]    inst,
  output logic [IMM_SEL_W-1:0] imm_sel_c,
  output logic [CLS_W-1:0]     cls_c,
  output logic                 wb_en_c
);

  inst_cls_e cls;

  assign cls_c = cls;

  // Opcode -> ImmSel / class / writeback enable
  always_comb begin
    imm_sel_c = IMM_U;
    cls       = CLS_ILLEGAL;
    wb_en_c   = 1'b0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        imm_sel_c = IMM_U;
        cls       = CLS_ALU;
        wb_en_c   = 1'b1;
      end
      OPC_OP_IMM, OPC_OP: begin
        imm_sel_c = IMM_I;
        cls       = CLS_ALU;
        wb_en_c   = 1'b1;
      end
      OPC_LOAD: begin
        imm_sel_c = IMM_I;
        cls       = CLS_LOAD;
        wb_en_c   = 1'b1;
      end
      OPC_JALR: begin
        imm_sel_c = IMM_I;
        cls       = CLS_JALR;
        wb_en_c   = 1'b1;
      end
      OPC_STORE: begin
        imm_sel_c = IMM_S;
        cls       = CLS_STORE;
      end
      OPC_BRANCH: begin
        imm_sel_c = IMM_B;
        cls       = CLS_BRANCH;
      end
      OPC_JAL: begin
        imm_sel_c = IMM_J;
        cls       = CLS_JAL;
        wb_en_c   = 1'b1;
      end
      OPC_SYSTEM: begin
        if (inst == INST_EBREAK) begin
          cls = CLS_EBREAK;
        end
`ifdef IMM_SEQ_CTRL_ZICSR_EN
        // funct3 x01/x10/x11 are CSR ops; bit 14 selects the zimm form
        else if (inst[13:12] != 2'b00) begin
          imm_sel_c = inst[14] ? IMM_ZIMM : IMM_I;
          cls       = CLS_CSR;
          wb_en_c   = 1'b1;
        end
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/imm_seq_ctrl.sv
// Multi-cycle control sequencer: IFU fetch handshake, decode to ImmSel,
// execute / memory / writeback sequencing with rf_we, pc_we and pc_sel.
// Ports: clk, rst (async active-high); run; IFU ifu_req/ifu_valid/ifu_inst;
// inst_out, ImmSel to the immediate generator; br_taken from the comparator;
// LSU mem_req/mem_we/mem_ack; rf_we, pc_we, pc_sel strobes; sticky halt,
// illegal, bus_err; state_dbg.
// Optional feature macro: IMM_SEQ_CTRL_ZICSR_EN (CSR decode, in imm_seq_decode).
module imm_seq_ctrl
  import imm_seq_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  output logic                 ifu_req,
  input  logic                 ifu_valid,
  input  logic [INST_W-1:0]    ifu_inst,
  output logic [INST_W-1:0]    inst_out,
  output logic [IMM_SEL_W-1:0] ImmSel,
  input  logic                 br_taken,
  output logic                 mem_req,
  output logic                 mem_we,
  input  logic                 mem_ack,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic [PC_SEL_W-1:0]  pc_sel,
  output logic                 halt,
  output logic                 illegal,
  output logic                 bus_err,
  output logic [2:0]           state_dbg
);

  localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT);
  localparam bit                WDOG_EN    = (TIMEOUT != 0);

  state_e              state, state_d;
  inst_cls_e           cls_q, cls_d;
  logic                wb_en_q, wb_en_d;
  logic [WDOG_W-1:0]   wdog_cnt, wdog_d;
  logic [INST_W-1:0]   inst_d;
  logic [IMM_SEL_W-1:0] imm_sel_d;
  logic [PC_SEL_W-1:0] pc_sel_d;
  logic                ifu_req_d, mem_req_d, mem_we_d, rf_we_d, pc_we_d;
  logic                halt_d, illegal_d, bus_err_d;
  logic                wdog_exp_c;

  logic [IMM_SEL_W-1:0] dec_imm_sel_c;
  logic [CLS_W-1:0]     dec_cls_c;
  logic                 dec_wb_en_c;

  imm_seq_decode u_decode (
    .inst      (inst_out),
    .imm_sel_c (dec_imm_sel_c),
    .cls_c     (dec_cls_c),
    .wb_en_c   (dec_wb_en_c)
  );

  assign state_dbg  = state;
  // Counter holds completed wait cycles; expiry is the cycle it reaches TIMEOUT
  assign wdog_exp_c = WDOG_EN && (wdog_cnt == WDOG_LIMIT);

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      cls_q    <= CLS_ALU;
      wb_en_q  <= 1'b0;
      wdog_cnt <= '0;
      inst_out <= '0;
      ImmSel   <= IMM_U;
      pc_sel   <= PC_SEL_SEQ;
      ifu_req  <= 1'b0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      rf_we    <= 1'b0;
      pc_we    <= 1'b0;
      halt     <= 1'b0;
      illegal  <= 1'b0;
      bus_err  <= 1'b0;
    end else begin
      state    <= state_d;
      cls_q    <= cls_d;
      wb_en_q  <= wb_en_d;
      wdog_cnt <= wdog_d;
      inst_out <= inst_d;
      ImmSel   <= imm_sel_d;
      pc_sel   <= pc_sel_d;
      ifu_req  <= ifu_req_d;
      mem_req  <= mem_req_d;
      mem_we   <= mem_we_d;
      rf_we    <= rf_we_d;
      pc_we    <= pc_we_d;
      halt     <= halt_d;
      illegal  <= illegal_d;
      bus_err  <= bus_err_d;
    end
  end

  // Next state and next output values; strobes default low, the rest hold
  always_comb begin
    state_d   = state;
    cls_d     = cls_q;
    wb_en_d   = wb_en_q;
    wdog_d    = wdog_cnt;
    inst_d    = inst_out;
    imm_sel_d = ImmSel;
    pc_sel_d  = pc_sel;
    halt_d    = halt;
    illegal_d = illegal;
    bus_err_d = bus_err;
    ifu_req_d = 1'b0;
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;
    rf_we_d   = 1'b0;
    pc_we_d   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (run) begin
          state_d   = ST_FETCH;
          ifu_req_d = 1'b1;
          wdog_d    = '0;
        end
      end
      ST_FETCH: begin
        if (ifu_valid) begin
          inst_d  = ifu_inst;
          state_d = ST_DECODE;
        end else if (wdog_exp_c) begin
          bus_err_d = 1'b1;
          state_d   = ST_STOP;
        end else begin
          ifu_req_d = 1'b1;
          wdog_d    = wdog_cnt + WDOG_W'(1);
        end
      end
      ST_DECODE: begin
        imm_sel_d = dec_imm_sel_c;
        cls_d     = inst_cls_e'(dec_cls_c);
        wb_en_d   = dec_wb_en_c;
        if (inst_cls_e'(dec_cls_c) == CLS_EBREAK) begin
          halt_d  = 1'b1;
          state_d = ST_STOP;
        end else if (inst_cls_e'(dec_cls_c) == CLS_ILLEGAL) begin
          illegal_d = 1'b1;
          state_d   = ST_STOP;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (cls_q == CLS_JAL) begin
          pc_sel_d = PC_SEL_REL;
        end else if (cls_q == CLS_JALR) begin
          pc_sel_d = PC_SEL_JALR;
        end else if (cls_q == CLS_BRANCH) begin
          pc_sel_d = br_taken ? PC_SEL_REL : PC_SEL_SEQ;
        end else begin
          pc_sel_d = PC_SEL_SEQ;
        end
        if (cls_q == CLS_LOAD || cls_q == CLS_STORE) begin
          state_d   = ST_MEM;
          mem_req_d = 1'b1;
          mem_we_d  = (cls_q == CLS_STORE);
          wdog_d    = '0;
        end else begin
          state_d = ST_WB;
          pc_we_d = 1'b1;
          rf_we_d = wb_en_q;
        end
      end
      ST_MEM: begin
        if (mem_ack) begin
          state_d = ST_WB;
          pc_we_d = 1'b1;
          rf_we_d = wb_en_q;
        end else if (wdog_exp_c) begin
          bus_err_d = 1'b1;
          state_d   = ST_STOP;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = (cls_q == CLS_STORE);
          wdog_d    = wdog_cnt + WDOG_W'(1);
        end
      end
      ST_WB: begin
        if (run) begin
          state_d   = ST_FETCH;
          ifu_req_d = 1'b1;
          wdog_d    = '0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_STOP: ;
      default: state_d = ST_STOP;
    endcase
  end

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// Self-checking bench for imm_seq_ctrl (TIMEOUT=4): directed steps plus
// randomized instructions compared against a transaction-level model.
module tb_imm_seq_ctrl;

  localparam int unsigned TO = 4;
  localparam int K_OK = 0, K_HALT = 1, K_ILL = 2;

  logic        clk, rst, run;
  logic        ifu_req, ifu_valid;
  logic [31:0] ifu_inst, inst_out;
  logic [2:0]  imm_sel;
  logic        br_taken, mem_req, mem_we, mem_ack;
  logic        rf_we, pc_we, halt, illegal, bus_err;
  logic [1:0]  pc_sel;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  imm_seq_ctrl #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .run(run),
    .ifu_req(ifu_req), .ifu_valid(ifu_valid), .ifu_inst(ifu_inst),
    .inst_out(inst_out), .ImmSel(imm_sel), .br_taken(br_taken),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .rf_we(rf_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .halt(halt), .illegal(illegal), .bus_err(bus_err),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  typedef struct packed {
    logic [1:0] kind;
    logic [2:0] imm;
    logic [1:0] pcs;
    logic       rf;
    logic       mem;
    logic       st;
  } exp_t;

  // Expected architectural effect of one instruction, from the opcode table
  function automatic exp_t model(input logic [31:0] ins, input logic br);
    exp_t e;
    logic [2:0] f3;
    e = '0;
    e.kind = 2'(K_OK);
    f3 = ins[14:12];
    case (ins[6:0])
      7'h37, 7'h17: begin e.imm = 3'd0; e.rf = 1'b1; end
      7'h13, 7'h33: begin e.imm = 3'd1; e.rf = 1'b1; end
      7'h03: begin e.imm = 3'd1; e.rf = 1'b1; e.mem = 1'b1; end
      7'h67: begin e.imm = 3'd1; e.rf = 1'b1; e.pcs = 2'd2; end
      7'h23: begin e.imm = 3'd2; e.mem = 1'b1; e.st = 1'b1; end
      7'h63: begin e.imm = 3'd3; e.pcs = br ? 2'd1 : 2'd0; end
      7'h6f: begin e.imm = 3'd4; e.rf = 1'b1; e.pcs = 2'd1; end
      7'h73: begin
        if (ins == 32'h0010_0073) e.kind = 2'(K_HALT);
`ifdef IMM_SEQ_CTRL_ZICSR_EN
        else if (f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd3) begin e.imm = 3'd1; e.rf = 1'b1; end
        else if (f3 == 3'd5 || f3 == 3'd6 || f3 == 3'd7) begin e.imm = 3'd5; e.rf = 1'b1; end
        else e.kind = 2'(K_ILL);
`else
        else e.kind = 2'(K_ILL);
`endif
      end
      default: e.kind = 2'(K_ILL);
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reset asynchronously mid-cycle, check reset values, release, expect IDLE
  task automatic do_reset();
    @(negedge clk);
    #2;
    rst = 1'b1; run = 1'b0; ifu_valid = 1'b0; mem_ack = 1'b0; br_taken = 1'b0;
    #1;
    chk("rst_state", 32'(state_dbg), 0);
    chk("rst_inst", inst_out, 0);
    chk("rst_immsel", 32'(imm_sel), 0);
    chk("rst_pc_sel", 32'(pc_sel), 0);
    chk("rst_strobes", {ifu_req, mem_req, mem_we, rf_we, pc_we}, 0);
    chk("rst_flags", {halt, illegal, bus_err}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_state", 32'(state_dbg), 0);
    chk("idle_req", 32'(ifu_req), 0);
  endtask

  task automatic start_run();
    run = 1'b1;
    @(negedge clk);
    chk("start_fetch", 32'(state_dbg), 1);
  endtask

  // One instruction from the first FETCH cycle. w: cycles before ifu_valid;
  // k: MEM cycle carrying mem_ack (0 = never); rn: run value sampled in WB.
  task automatic do_inst(input logic [31:0] ins, input int w, input int k,
                         input logic br, input logic rn, output logic stopped);
    exp_t e;
    int n;
    e = model(ins, br);
    stopped = 1'b0;
    chk("fetch_state", 32'(state_dbg), 1);
    chk("fetch_req", 32'(ifu_req), 1);
    for (int i = 0; i < w; i++) begin
      ifu_valid = 1'b0;
      @(negedge clk);
      chk("fetch_wait_req", 32'(ifu_req), 1);
    end
    ifu_valid = 1'b1; ifu_inst = ins;
    @(negedge clk);
    // ifu_valid / mem_ack noise must be ignored in DECODE and EXEC
    ifu_valid = 1'($urandom); mem_ack = 1'($urandom); ifu_inst = $urandom;
    br_taken = br;
    chk("decode_state", 32'(state_dbg), 2);
    chk("inst_out", inst_out, ins);
    chk("decode_req", 32'(ifu_req), 0);
    if (32'(e.kind) != K_OK) begin
      @(negedge clk);
      ifu_valid = 1'b0; mem_ack = 1'b0;
      chk("stop_state", 32'(state_dbg), 6);
      chk("halt", 32'(halt), (32'(e.kind) == K_HALT) ? 1 : 0);
      chk("illegal", 32'(illegal), (32'(e.kind) == K_ILL) ? 1 : 0);
      chk("stop_bus_err", 32'(bus_err), 0);
      stopped = 1'b1;
      return;
    end
    @(negedge clk);
    ifu_valid = 1'($urandom); mem_ack = 1'($urandom);
    chk("exec_state", 32'(state_dbg), 3);
    chk("immsel", 32'(imm_sel), 32'(e.imm));
    @(negedge clk);
    ifu_valid = 1'b0; mem_ack = 1'b0;
    if (e.mem) begin
      n = 0;
      while (state_dbg == 3'd4 && n < 20) begin
        chk("mem_req", 32'(mem_req), 1);
        chk("mem_we", 32'(mem_we), 32'(e.st));
        n++;
        if (n == k) mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
      end
      if (k == 0) begin
        chk("mem_timeout_cycles", n, TO + 1);
        chk("mem_bus_err", 32'(bus_err), 1);
        chk("mem_to_state", 32'(state_dbg), 6);
        chk("mem_to_req", 32'(mem_req), 0);
        stopped = 1'b1;
        return;
      end
      chk("mem_cycles", n, k);
    end
    chk("wb_state", 32'(state_dbg), 5);
    chk("wb_pc_we", 32'(pc_we), 1);
    chk("wb_rf_we", 32'(rf_we), 32'(e.rf));
    chk("wb_pc_sel", 32'(pc_sel), 32'(e.pcs));
    chk("wb_mem_req", 32'(mem_req), 0);
    run = rn;
    @(negedge clk);
    chk("post_wb_strobes", {rf_we, pc_we}, 0);
    chk("post_wb_state", 32'(state_dbg), rn ? 1 : 0);
    if (!rn) begin
      @(negedge clk);
      chk("idle_hold", 32'(state_dbg), 0);
      chk("idle_no_req", 32'(ifu_req), 0);
      run = 1'b1;
      @(negedge clk);
      chk("restart_fetch", 32'(state_dbg), 1);
    end
  endtask

  logic [6:0]  opc_tab [9] = '{7'h37, 7'h17, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h6f, 7'h33};
  logic [31:0] rins;
  logic        st;
  int          r, n;

  initial begin
    rst = 1'b0; run = 1'b0; ifu_valid = 1'b0; ifu_inst = '0;
    br_taken = 1'b0; mem_ack = 1'b0;
    do_reset();
    start_run();

    do_inst(32'h0050_0093, 0, 1, 1'b0, 1'b1, st); // addi
    do_inst(32'h0011_2223, 0, 3, 1'b0, 1'b1, st); // sw, ack in 3rd MEM cycle
    do_inst(32'h0020_8463, 0, 1, 1'b1, 1'b1, st); // beq taken
    do_inst(32'h0020_8463, 1, 1, 1'b0, 1'b1, st); // beq not taken
    do_inst(32'h0080_00EF, 0, 1, 1'b0, 1'b1, st); // jal
    do_inst(32'h0000_80E7, 2, 1, 1'b1, 1'b1, st); // jalr
    do_inst(32'h0000_2083, TO, TO + 1, 1'b0, 1'b0, st); // lw, valid/ack on expiry cycle
    do_inst(32'h0000_0037, 0, 1, 1'b0, 1'b1, st); // lui

    // Randomized instruction stream
    for (int t = 0; t < 150; t++) begin
      r = $urandom_range(0, 11);
      rins = $urandom;
      if (r < 9) rins[6:0] = opc_tab[r];
      else if (r == 9) rins[6:0] = 7'h73;
      do_inst(rins, $urandom_range(0, TO), $urandom_range(1, TO + 1),
              1'($urandom), ($urandom_range(0, 3) != 0), st);
      if (st) begin
        do_reset();
        start_run();
      end
    end

    // ebreak halts; STOP ignores run
    do_inst(32'h0010_0073, 0, 1, 1'b0, 1'b1, st);
    chk("ebreak_stopped", 32'(st), 1);
    repeat (3) @(negedge clk);
    chk("stop_ignores_run", 32'(state_dbg), 6);
    chk("stop_halt_sticky", 32'(halt), 1);
    do_reset();
    start_run();

    // csrrwi: CSR with the feature, illegal without
    do_inst(32'h3402_D073, 0, 1, 1'b0, 1'b1, st);
    if (st) begin
      do_reset();
      start_run();
    end

    // Load whose ack never arrives
    do_inst(32'h0000_2083, 0, 0, 1'b0, 1'b1, st);
    do_reset();
    start_run();

    // Fetch never answered: ifu_req for TIMEOUT+1 cycles, then bus_err
    n = 0;
    while (ifu_req && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("fetch_timeout_cycles", n, TO + 1);
    chk("fetch_bus_err", 32'(bus_err), 1);
    chk("fetch_to_state", 32'(state_dbg), 6);
    chk("fetch_to_req", 32'(ifu_req), 0);
    repeat (2) @(negedge clk);
    chk("bus_err_sticky", 32'(bus_err), 1);
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
